// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: the ROM read port and the decode valid/ready handshake.
// master = fetch_sequencer, slave = ROM/decode side.
`timescale 1ns/1ps
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 6
);
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_data;
  logic [ADDR_W+1:0] inst_pc;

  modport master (
    output rom_addr,
    input  rom_data,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues ROM reads, tracks ROM latency in a
// shift pipe, buffers returned words in a small FIFO and hands them to decode.
// Optional feature macro FETCH_BOUND_CHECK_EN: stop fetching at ROM_DEPTH and flag
// fetch_fault_o once the buffered words have drained.
`timescale 1ns/1ps
module fetch_sequencer #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned ROM_DEPTH = 12,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  halt_req_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_W+1:0]     redirect_pc_i,
  fetch_sequencer_if.master     fetch_io,
  output logic                  busy_o,
  output logic                  fetch_fault_o
);

  localparam int unsigned PC_W  = ADDR_W + 2;
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

`ifdef FETCH_BOUND_CHECK_EN
  localparam bit BoundCheck = 1'b1;
`else
  localparam bit BoundCheck = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StHalt} state_e;

  state_e               state_q;
  logic [PC_W-1:0]      pc_q;
  logic [ADDR_W-1:0]    rom_addr_q;
  logic [ROM_LAT-1:0]   pipe_vld_q;
  logic [PC_W-1:0]      pipe_pc_q   [ROM_LAT];
  logic [31:0]          fifo_data_q [BUF_DEPTH];
  logic [PC_W-1:0]      fifo_pc_q   [BUF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 oob_q;
  logic                 fault_q;

  logic                 redir, pop, push, issue, oob;
  int unsigned          inflight, occ;

  // Per-cycle handshake decisions: redirect, pop, capture and issue credit.
  always_comb begin
    redir    = redirect_valid_i && (state_q == StRun || state_q == StDrain);
    inflight = 0;
    for (int i = 0; i < ROM_LAT; i++) inflight += 32'(pipe_vld_q[i]);
    pop  = (cnt_q != '0) && fetch_io.inst_ready && !redir;
    push = pipe_vld_q[ROM_LAT-1] && !redir;
    // A pop this cycle frees a slot, so it returns a credit to the issue check.
    occ  = 32'(cnt_q) + inflight - 32'(pop);
    oob  = BoundCheck && (32'(pc_q[PC_W-1:2]) >= ROM_DEPTH);
    issue = (state_q == StRun) && !halt_req_i && !redir && !oob && (occ < BUF_DEPTH);
  end

  // FSM, PC, latency pipe and FIFO state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      rom_addr_q <= '0;
      pipe_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      oob_q      <= 1'b0;
      fault_q    <= 1'b0;
      for (int i = 0; i < ROM_LAT; i++) pipe_pc_q[i] <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      pipe_vld_q[0] <= issue;
      pipe_pc_q[0]  <= pc_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_pc_q[i]  <= pipe_pc_q[i-1];
      end

      if (issue) begin
        rom_addr_q <= pc_q[PC_W-1:2];
        pc_q       <= pc_q + PC_W'(4);
      end

      if (redir) begin
        // Dropping the valid bits makes every in-flight read stale.
        pipe_vld_q <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        cnt_q      <= '0;
      end else begin
        if (push) begin
          fifo_data_q[wr_ptr_q] <= fetch_io.rom_data;
          fifo_pc_q[wr_ptr_q]   <= pipe_pc_q[ROM_LAT-1];
          wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end

      unique case (state_q)
        StIdle, StHalt: begin
          if (start_i) begin
            state_q <= StRun;
            pc_q    <= '0;
            oob_q   <= 1'b0;
            fault_q <= 1'b0;
          end
        end
        StRun: begin
          if (redir) begin
            pc_q  <= redirect_pc_i & ~PC_W'(3);
            oob_q <= 1'b0;
          end else if (halt_req_i) begin
            state_q <= StDrain;
          end else if (oob) begin
            state_q <= StDrain;
            oob_q   <= 1'b1;
          end
        end
        StDrain: begin
          if (redir) begin
            pc_q  <= redirect_pc_i & ~PC_W'(3);
            oob_q <= 1'b0;
            if (!halt_req_i) state_q <= StRun;
          end else if (inflight == 0 && cnt_q == '0) begin
            state_q <= StHalt;
            fault_q <= oob_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fetch_io.rom_addr   = rom_addr_q;
  assign fetch_io.inst_valid = (cnt_q != '0);
  assign fetch_io.inst_data  = (cnt_q != '0) ? fifo_data_q[rd_ptr_q] : '0;
  assign fetch_io.inst_pc    = (cnt_q != '0) ? fifo_pc_q[rd_ptr_q] : '0;
  assign busy_o              = (state_q == StRun) || (state_q == StDrain);
  assign fetch_fault_o       = BoundCheck && fault_q;

endmodule
